ps2_receive: RTL and testbench



---
 rtl/ps2_receive.sv | 181 ++++++++++++++++++
 tb/tb_ps2_receive.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receive.sv
// ps2_receive: host-side PS/2 device-to-host frame receiver.
// Synchronizes the PS/2 clock and data pins and detects falling edges of the
// PS/2 clock. It then deserializes start, 8 data bits (LSB first), odd parity
// and stop. A good byte is presented on data_out with a one-cycle data_valid
// strobe. A bad frame gives a one-cycle frame_error strobe instead.
// Optional feature macro: PS2_RX_PARITY_CHECK_EN. When it is defined, a
// parity failure is reported as a frame error. When it is undefined, the
// parity bit is sampled but never checked.
module ps2_receive #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read_enable,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic [CNT_WIDTH-1:0]   timeout_cnt_q, timeout_cnt_d;

  logic clk_s;
  logic data_s;
  logic fall_edge;
  logic timeout_hit;
  logic parity_ok;
  logic frame_ok;

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign fall_edge = clk_prev_q & ~clk_s;

  // Odd parity: the data bits and the parity bit together hold an odd number of ones.
  assign parity_ok = ^{shift_q, parity_q};

`ifdef PS2_RX_PARITY_CHECK_EN
  assign frame_ok = data_s & parity_ok;
`else
  logic parity_unused;
  assign parity_unused = parity_ok;
  assign frame_ok      = data_s;
`endif

  // An edge in the same cycle always wins over an expiring inter-edge timer.
  assign timeout_hit = (state_q != IDLE) && !fall_edge && (timeout_cnt_q == TIMEOUT_LAST);

  // Shift both asynchronous pins through the synchronizer chain and remember the last synced clock.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_s;
  end

  // Inter-edge timer: held at zero in IDLE and on each edge, otherwise counting.
  always_comb begin
    timeout_cnt_d = timeout_cnt_q + CNT_WIDTH'(1);
    if (state_q == IDLE || fall_edge) begin
      timeout_cnt_d = '0;
    end
  end

  // Frame FSM: next state, deserializer, output register and strobes.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    if (!read_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall_edge && !data_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          if (fall_edge) begin
            shift_d   = {data_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end else if (timeout_hit) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
          end
        end
        PARITY: begin
          if (fall_edge) begin
            parity_d = data_s;
            state_d  = STOP;
          end else if (timeout_hit) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
          end
        end
        STOP: begin
          if (fall_edge) begin
            state_d = IDLE;
            if (frame_ok) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end else if (timeout_hit) begin
            state_d       = IDLE;
            frame_error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset; synchronizers reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q    <= {SYNC_STAGES{1'b1}};
      data_sync_q   <= {SYNC_STAGES{1'b1}};
      clk_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receive.sv
// tb_ps2_receive: self-checking bench for ps2_receive.
// Directed frame table, hand-written corner sequences (timeout, abort, ignored
// edge, reset mid-frame) and randomized frames against a frame-level model.
module tb_ps2_receive;

  localparam int SYNC = 2;
  localparam int TMO  = 300;
  localparam int CW   = 16;

`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_enable;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_valid_byte = 8'h00;
  logic [7:0] model_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;

  ps2_receive #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read_enable(read_enable),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Strobe monitor: counts pulses, captures the byte on data_valid, checks exclusivity and width.
  always @(negedge clk) begin
    if (data_valid || frame_error) begin
      checkOutput("strobe_exclusive", int'(data_valid & frame_error), 0);
      checkOutput("strobe_width", int'((data_valid & prev_valid) | (frame_error & prev_err)), 0);
    end
    if (data_valid) begin
      valid_cnt++;
      last_valid_byte = data_out;
    end
    if (frame_error) err_cnt++;
    prev_valid = data_valid;
    prev_err   = frame_error;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] bits, input int count, input int half);
    for (int i = 0; i < count; i++) begin
      ps2_data = bits[i];
      waitCycles(half);
      ps2_clock = 1'b0;
      waitCycles(half);
      ps2_clock = 1'b1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int v0;
    int e0;
    int half;
    v0   = valid_cnt;
    e0   = err_cnt;
    half = $urandom_range(6, 16);
    waitCycles($urandom_range(4, 20));
    sendBits(makeFrame(v.data, v.par_flip, v.stop), 11, half);
    ps2_data = 1'b1;
    waitCycles(SYNC + 6);
    checkOutput({tag, "_valid"}, valid_cnt - v0, int'(v.exp_valid));
    checkOutput({tag, "_err"}, err_cnt - e0, int'(v.exp_err));
    if (v.exp_valid) checkOutput({tag, "_byte"}, int'(last_valid_byte), int'(v.data));
    checkOutput({tag, "_data_out"}, int'(data_out), int'(v.exp_data));
    checkOutput({tag, "_busy"}, int'(busy), 0);
    model_data = v.exp_data;
  endtask

  initial begin
    vec_t tbl[7];
    vec_t rv;
    int   v0;
    int   e0;
    int   waited;
    bit   seen;
    bit   good;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, !PARITY_EN, PARITY_EN, 8'h1C};
    tbl[2] = '{8'hFA, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80};
    tbl[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};

    reset       = 1'b1;
    read_enable = 1'b1;
    ps2_clock   = 1'b1;
    ps2_data    = 1'b1;
    waitCycles(3);
    checkOutput("rst_data_out", int'(data_out), 0);
    checkOutput("rst_valid", int'(data_valid), 0);
    checkOutput("rst_err", int'(frame_error), 0);
    checkOutput("rst_busy", int'(busy), 0);
    reset = 1'b0;
    waitCycles(2);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i], $sformatf("tbl%0d", i));
    end

    // Timeout: start plus 5 data bits, then the clock stays high.
    v0 = valid_cnt;
    e0 = err_cnt;
    waitCycles(10);
    sendBits(makeFrame(8'hAA, 1'b0, 1'b1), 6, 10);
    checkOutput("to_busy_before", int'(busy), 1);
    waited = 10;
    seen   = 1'b0;
    while (!seen && waited < 3 * TMO) begin
      @(negedge clk);
      waited++;
      if (frame_error) seen = 1'b1;
    end
    checkOutput("to_seen", int'(seen), 1);
    checkOutput("to_latency_in_window", int'(waited >= TMO && waited <= TMO + SYNC + 4), 1);
    waitCycles(2);
    checkOutput("to_busy_after", int'(busy), 0);
    checkOutput("to_err_count", err_cnt - e0, 1);
    checkOutput("to_valid_count", valid_cnt - v0, 0);
    checkOutput("to_data_out", int'(data_out), int'(model_data));
    rv = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA};
    applyStimulus(rv, "after_to");

    // Abort: read_enable dropped after the 4th data bit.
    v0 = valid_cnt;
    e0 = err_cnt;
    waitCycles(10);
    sendBits(makeFrame(8'h3C, 1'b0, 1'b1), 5, 10);
    checkOutput("abort_busy_before", int'(busy), 1);
    read_enable = 1'b0;
    waitCycles(1);
    checkOutput("abort_busy_next", int'(busy), 0);
    waitCycles(TMO + 20);
    read_enable = 1'b1;
    waitCycles(5);
    checkOutput("abort_valid_count", valid_cnt - v0, 0);
    checkOutput("abort_err_count", err_cnt - e0, 0);
    checkOutput("abort_data_out", int'(data_out), int'(model_data));

    // A falling edge with data high in IDLE is not a start bit.
    e0 = err_cnt;
    ps2_data = 1'b1;
    waitCycles(10);
    ps2_clock = 1'b0;
    waitCycles(10);
    ps2_clock = 1'b1;
    waitCycles(5);
    checkOutput("ignore_busy", int'(busy), 0);
    waitCycles(TMO + 20);
    checkOutput("ignore_err_count", err_cnt - e0, 0);

    // Reset mid-frame discards the partial frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    sendBits(makeFrame(8'h0F, 1'b0, 1'b1), 4, 10);
    checkOutput("mrst_busy_before", int'(busy), 1);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("mrst_data_out", int'(data_out), 0);
    checkOutput("mrst_valid", int'(data_valid), 0);
    checkOutput("mrst_err", int'(frame_error), 0);
    checkOutput("mrst_busy", int'(busy), 0);
    reset      = 1'b0;
    model_data = 8'h00;
    ps2_data   = 1'b1;
    waitCycles(TMO + 20);
    checkOutput("mrst_valid_count", valid_cnt - v0, 0);
    checkOutput("mrst_err_count", err_cnt - e0, 0);
    rv = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
    applyStimulus(rv, "after_mrst");

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      rv.data     = 8'($urandom);
      rv.par_flip = ($urandom_range(0, 3) == 0);
      rv.stop     = ($urandom_range(0, 7) != 0);
      good        = rv.stop && !(PARITY_EN && rv.par_flip);
      rv.exp_valid = good;
      rv.exp_err   = !good;
      rv.exp_data  = good ? rv.data : model_data;
      applyStimulus(rv, $sformatf("rnd%0d", i));
    end

    waitCycles(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
